bitmanip_clmul_unit: RTL and testbench
======================================

BITMANIP_CLMUL_UNIT -- requirements
Module: bitmanip_clmul_unit

Interface
REQ-001 Parameter XLEN, default 64: operand/result width; SHALL accept only 32 or 64.
REQ-002 Parameter BITS_PER_CYCLE, default 4: operand_b bits consumed per iteration; SHALL accept only 1, 2, 4 or 8.
REQ-003 Parameter EARLY_OUT, default 1: when 1, iteration ends as soon as the unconsumed operand_b bits are all zero.
REQ-004 Parameter TRANS_ID_BITS, default 3: width of the transaction tag.
REQ-005 clk_i  in  1  sole clock, all state on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 flush_i  in  1  abort the in-flight operation.
REQ-008 valid_i  in  1  request valid.
REQ-009 ready_o  out  1  unit can accept a request.
REQ-010 op_i  in  2  00 CLMUL, 01 CLMULH, 10 CLMULR, 11 reserved.
REQ-011 operand_a_i, operand_b_i  in  XLEN each  source operands.
REQ-012 trans_id_i  in  TRANS_ID_BITS  request tag.
REQ-013 valid_o  out  1  result valid.
REQ-014 result_ready_i  in  1  consumer accepts result.
REQ-015 result_o  out  XLEN  carry-less result.
REQ-016 trans_id_o  out  TRANS_ID_BITS  tag of the returned result.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-018 ready_o SHALL equal (state==IDLE) && !flush_i, driven combinationally.
REQ-019 Acceptance occurs on the edge where valid_i && ready_o; the unit SHALL then capture op_i, operands and trans_id_i, clear the 2*XLEN accumulator, and move to BUSY, or to DONE with result 0 for op 11.
REQ-020 Each BUSY cycle SHALL XOR (a << k) into the accumulator for every set bit k among the next BITS_PER_CYCLE unconsumed bits of b, LSB first; k is the absolute bit index.
REQ-021 BUSY SHALL last exactly XLEN/BITS_PER_CYCLE cycles when EARLY_OUT=0.
REQ-022 When EARLY_OUT=1, BUSY SHALL last the minimum number of cycles, at least 1, after which all remaining b bits are zero.
REQ-023 On leaving BUSY the unit SHALL enter DONE with result_o set as follows:
- CLMUL: acc[XLEN-1:0]
- CLMULH: acc[2XLEN-1:XLEN]
- CLMULR: acc[2XLEN-2:XLEN-1]
REQ-024 In DONE, valid_o SHALL be 1, and result_o and trans_id_o SHALL be held stable until result_ready_i is high.
REQ-025 The DONE-to-IDLE transition SHALL occur on the edge where valid_o && result_ready_i; ready_o rises the following cycle, giving one bubble.
REQ-026 flush_i SHALL force IDLE on the next edge from any state; valid_o=0 on that edge; the flushed result is never presented.
REQ-027 flush_i has priority over acceptance and over the DONE handshake in the same cycle.
REQ-028 valid_o SHALL be 0 in IDLE and BUSY.
REQ-029 The iteration counter SHALL be log2(XLEN/BITS_PER_CYCLE)+1 bits wide and SHALL never wrap.

Reset
REQ-030 While rst_i is high on an edge, the unit SHALL go to IDLE and clear valid_o, result_o, trans_id_o, the accumulator and the counter to 0.
REQ-031 rst_i SHALL override flush_i and any in-flight operation, with no output produced for that operation.
REQ-032 ready_o SHALL be 0 during reset cycles and 1 in the first cycle after rst_i falls, provided flush_i is 0.

Verification (XLEN=64, BITS_PER_CYCLE=4, EARLY_OUT=1 unless stated)
REQ-033 CLMUL a=3, b=3, tag 5 -> valid_o high after 1 BUSY cycle, result_o=0x5, trans_id_o=5.
REQ-034 a=0x8000_0000_0000_0000, b=2:
- CLMUL -> 0
- CLMULH -> 0x1
- CLMULR -> 0x2
REQ-035 CLMUL a=1, b=all-ones -> 16 BUSY cycles, result_o=0xFFFF_FFFF_FFFF_FFFF. With EARLY_OUT=0 and b=1 -> also 16 BUSY cycles, result_o=0x1.
REQ-036 Backpressure: hold result_ready_i=0 for 5 cycles in DONE -> valid_o, result_o and trans_id_o stable, ready_o=0; raise result_ready_i -> ready_o=1 on the next cycle.
REQ-037 flush_i asserted in the 3rd BUSY cycle -> no valid_o pulse, ready_o=1 in the cycle after the flush, and the following CLMUL a=3, b=3 returns 0x5.
REQ-038 rst_i asserted mid-BUSY and in DONE -> all outputs 0 next cycle, ready_o=1 after release, and op 11 then returns 0 with 0 BUSY cycles.

Source files
------------

// File: rtl/bitmanip_clmul_unit.sv
// bitmanip_clmul_unit: iterative carry-less multiply (CLMUL/CLMULH/CLMULR) with early-out, flush and result handshake
module bitmanip_clmul_unit #(
   parameter int XLEN = 64,
   parameter int BITS_PER_CYCLE = 4,
   parameter int EARLY_OUT = 1,
   parameter int TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [1:0]               op_i,
   input  logic [XLEN-1:0]          operand_a_i,
   input  logic [XLEN-1:0]          operand_b_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   output logic                     valid_o,
   input  logic                     result_ready_i,
   output logic [XLEN-1:0]          result_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o
);
   localparam int ITERS = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(ITERS) + 1;
   if (!(XLEN == 32 || XLEN == 64) ||
       !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_param
      $error("bitmanip_clmul_unit: unsupported XLEN or BITS_PER_CYCLE");
   end
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic [1:0] op_q;
   logic [2*XLEN-1:0] a_sh, acc, acc_nxt;
   logic [XLEN-1:0] b_q, b_rest, res_sel;
   logic [CW-1:0] cnt;
   logic last;
   assign ready_o = state == IDLE && !flush_i && !rst_i;
   assign valid_o = state == DONE;
   assign b_rest = b_q >> BITS_PER_CYCLE;
   assign last = (EARLY_OUT != 0 && b_rest == '0) || cnt == CW'(ITERS - 1);
   always_comb begin
      acc_nxt = acc;
      for (int j = 0; j < BITS_PER_CYCLE; j++)
         acc_nxt = b_q[j] ? acc_nxt ^ (a_sh << j) : acc_nxt;
   end
   assign res_sel = op_q == 2'b00 ? acc_nxt[XLEN-1:0] :
                    op_q == 2'b01 ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-2:XLEN-1];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         op_q <= '0;
         a_sh <= '0;
         b_q <= '0;
         acc <= '0;
         cnt <= '0;
         result_o <= '0;
         trans_id_o <= '0;
      end else if (flush_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (valid_i) begin
               op_q <= op_i;
               a_sh <= {{XLEN{1'b0}}, operand_a_i};
               b_q <= operand_b_i;
               acc <= '0;
               cnt <= '0;
               result_o <= '0;
               trans_id_o <= trans_id_i;
               state <= op_i == 2'b11 ? DONE : BUSY;
            end
            BUSY: begin
               acc <= acc_nxt;
               a_sh <= a_sh << BITS_PER_CYCLE;
               b_q <= b_rest;
               cnt <= cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  result_o <= res_sel;
               end
            end
            DONE: if (result_ready_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bitmanip_clmul_unit.sv
// tb_bitmanip_clmul_unit: table, random and corner-case checks of bitmanip_clmul_unit against a bit-level model
module tb_bitmanip_clmul_unit;
   logic clk = 0, rst = 1, flush = 0, valid = 0, valid2 = 0, result_ready = 0;
   logic [1:0] op = 0;
   logic [63:0] a = 0, b = 0;
   logic [2:0] tag = 0;
   logic ready, vout, ready2, vout2;
   logic [63:0] res, res2;
   logic [2:0] tid, tid2;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   bitmanip_clmul_unit dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready),
      .op_i(op), .operand_a_i(a), .operand_b_i(b), .trans_id_i(tag),
      .valid_o(vout), .result_ready_i(result_ready), .result_o(res), .trans_id_o(tid));
   bitmanip_clmul_unit #(.EARLY_OUT(0)) dut2 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid2), .ready_o(ready2),
      .op_i(op), .operand_a_i(a), .operand_b_i(b), .trans_id_i(tag),
      .valid_o(vout2), .result_ready_i(1'b1), .result_o(res2), .trans_id_o(tid2));
   typedef struct {
      logic [1:0] op;
      logic [63:0] a, b;
      logic [2:0] tag;
      logic [63:0] res;
      int busy;
   } vec_t;
   vec_t vecs[6];
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask
   function automatic logic [63:0] model_res(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [127:0] p = '0;
      for (int i = 0; i < 64; i++)
         if (y[i]) p ^= {64'b0, x} << i;
      return o == 0 ? p[63:0] : o == 1 ? p[127:64] : o == 2 ? p[126:63] : 64'h0;
   endfunction
   function automatic int model_busy(input logic [1:0] o, input logic [63:0] y);
      int h = -1;
      if (o == 3) return 0;
      for (int i = 0; i < 64; i++)
         if (y[i]) h = i;
      return h < 0 ? 1 : h / 4 + 1;
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic start(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y, input logic [2:0] t);
      chk("ready_before_accept", ready, 1);
      op = o; a = x; b = y; tag = t; valid = 1;
      tick();
      valid = 0;
   endtask
   task automatic wait_done(output int busy);
      busy = 0;
      while (!vout && busy < 100) begin
         busy++;
         tick();
      end
   endtask
   task automatic do_op(input string name, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [2:0] t, input logic [63:0] er, input int eb);
      int busy;
      start(o, x, y, t);
      wait_done(busy);
      chk({name, "_busy"}, busy, eb);
      chk({name, "_valid"}, vout, 1);
      chk({name, "_result"}, res, er);
      chk({name, "_tag"}, tid, t);
      result_ready = 1;
      tick();
      result_ready = 0;
      chk({name, "_valid_drop"}, vout, 0);
   endtask
   initial begin
      int busy;
      logic [63:0] hr;
      logic [2:0] ht;
      vecs[0] = '{2'd0, 64'h3, 64'h3, 3'd5, 64'h5, 1};
      vecs[1] = '{2'd0, 64'h8000_0000_0000_0000, 64'h2, 3'd1, 64'h0, 1};
      vecs[2] = '{2'd1, 64'h8000_0000_0000_0000, 64'h2, 3'd2, 64'h1, 1};
      vecs[3] = '{2'd2, 64'h8000_0000_0000_0000, 64'h2, 3'd3, 64'h2, 1};
      vecs[4] = '{2'd0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 16};
      vecs[5] = '{2'd3, 64'h1234, 64'h5678, 3'd6, 64'h0, 0};
      tick();
      chk("ready_in_reset", ready, 0);
      tick();
      chk("reset_valid", vout, 0);
      chk("reset_result", res, 0);
      chk("reset_tag", tid, 0);
      rst = 0;
      #1;
      chk("ready_after_reset", ready, 1);
      for (int i = 0; i < 6; i++)
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].busy);
      for (int i = 0; i < 40; i++) begin
         logic [1:0] ro;
         logic [63:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(0, 64);
         do_op($sformatf("rand%0d", i), ro, ra, rb, 3'($urandom), model_res(ro, ra, rb), model_busy(ro, rb));
      end
      valid2 = 1; op = 0; a = 64'h1; b = 64'h1;
      tick();
      valid2 = 0;
      busy = 0;
      while (!vout2 && busy < 100) begin
         busy++;
         tick();
      end
      chk("noearly_busy", busy, 16);
      chk("noearly_result", res2, 64'h1);
      start(2'd0, 64'h3, 64'h3, 3'd2);
      wait_done(busy);
      hr = res; ht = tid;
      chk("bp_result", hr, 64'h5);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", vout, 1);
         chk("bp_result_hold", res, hr);
         chk("bp_tag_hold", tid, ht);
         chk("bp_ready_low", ready, 0);
      end
      result_ready = 1;
      tick();
      result_ready = 0;
      chk("bp_ready_after", ready, 1);
      chk("bp_valid_after", vout, 0);
      start(2'd0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7);
      tick();
      tick();
      chk("flush_no_valid_busy", vout, 0);
      flush = 1;
      #1;
      chk("ready_low_in_flush", ready, 0);
      tick();
      flush = 0;
      #1;
      chk("flush_ready", ready, 1);
      for (int i = 0; i < 20; i++) begin
         chk("flush_no_valid", vout, 0);
         tick();
      end
      do_op("after_flush", 2'd0, 64'h3, 64'h3, 3'd5, 64'h5, 1);
      start(2'd0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3);
      tick();
      rst = 1;
      tick();
      chk("rst_busy_valid", vout, 0);
      chk("rst_busy_result", res, 0);
      chk("rst_busy_tag", tid, 0);
      chk("rst_busy_ready", ready, 0);
      rst = 0;
      #1;
      chk("rst_busy_ready_after", ready, 1);
      start(2'd0, 64'h3, 64'h3, 3'd6);
      wait_done(busy);
      chk("rst_done_reached", vout, 1);
      rst = 1;
      tick();
      chk("rst_done_valid", vout, 0);
      chk("rst_done_result", res, 0);
      chk("rst_done_tag", tid, 0);
      rst = 0;
      #1;
      chk("rst_done_ready_after", ready, 1);
      do_op("op11_after_rst", 2'd3, 64'hFFFF, 64'hFFFF, 3'd4, 64'h0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
